// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: bus field widths, FSM states,
// and the command/response records passed between the bridge and its FIFO.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

  localparam int APB_ADDR_W = `APB_ADDR_WIDTH;
  localparam int APB_DATA_W = `APB_DATA_WIDTH;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef logic [APB_ADDR_W-1:0] addr_t;
  typedef logic [APB_DATA_W-1:0] data_t;
  typedef logic [APB_STRB_W-1:0] strb_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_fsm_enum;

  typedef struct packed {
    logic  write;
    addr_t addr;
    data_t wdata;
    strb_t strb;
  } apb_cmd_t;

  typedef struct packed {
    data_t rdata;
    logic  slverr;
    logic  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_rsp_fifo.sv
// Two-entry in-order response FIFO; slot 0 is always the head, so the
// consumer-facing fields come straight out of a register.
module apb_rsp_fifo
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  apb_rsp_t   push_rsp_i,
  input  logic       pop_i,
  output apb_rsp_t   head_o,
  output logic [1:0] count_o
);

  apb_rsp_t   slot_q [2];
  apb_rsp_t   slot_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       wr_idx;

  // Write lands behind whatever survives this cycle's pop.
  assign wr_idx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop_i);

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    if (pop_i) begin
      slot_d[0] = slot_q[1];
      slot_d[1] = '0;
    end
    if (push_i) begin
      slot_d[wr_idx] = push_rsp_i;
    end
  end

  // NOTE: the two slots are reset (unlike a large RAM) so the head reads 0
  // when empty; state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      cnt_q     <= 2'd0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = slot_q[0];
  assign count_o = cnt_q;

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response channel to single-transfer APB master with a 2-deep
// response buffer. Optional ACCESS timeout enabled by APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_fsm_enum state_q, state_d;
  apb_cmd_t    xfer_q, xfer_d, cmd_in;
  logic        psel_q, psel_d, penable_q, penable_d;
  logic        accept, push, pop, tmo_hit;
  logic [1:0]  rsp_cnt, rsp_cnt_next;
  apb_rsp_t    push_rsp, rsp_head;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Fires on the ACCESS cycle whose wait would bring the count to the limit.
  assign tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SETUP) tmo_d = '0;
    else if ((state_q == ACCESS) && !PREADY) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign push         = (state_q == ACCESS) && (PREADY || tmo_hit);
  assign pop          = rsp_valid && rsp_ready;
  assign rsp_cnt_next = rsp_cnt + {1'b0, push} - {1'b0, pop};
  assign cmd_ready    = ((state_q == IDLE) || ((state_q == ACCESS) && PREADY))
                        && (rsp_cnt_next < 2'd2);
  assign accept       = cmd_valid && cmd_ready;

  always_comb begin
    cmd_in.write = cmd_write;
    cmd_in.addr  = cmd_addr;
    cmd_in.wdata = cmd_wdata;
    cmd_in.strb  = cmd_write ? cmd_strb : '0;
  end

  always_comb begin
    push_rsp.rdata   = xfer_q.write ? '0 : PRDATA;
    push_rsp.slverr  = PSLVERR;
    push_rsp.timeout = 1'b0;
    if (tmo_hit) begin
      push_rsp.rdata   = '0;
      push_rsp.slverr  = 1'b1;
      push_rsp.timeout = 1'b1;
    end
  end

  // NOTE: every always_comb output is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          xfer_d  = cmd_in;
          psel_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY && accept) begin
          state_d   = SETUP;
          xfer_d    = cmd_in;
          penable_d = 1'b0;
        end else if (PREADY || tmo_hit) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      xfer_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xfer_q    <= xfer_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  apb_rsp_fifo u_rsp_fifo (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .push_i     (push),
    .push_rsp_i (push_rsp),
    .pop_i      (pop),
    .head_o     (rsp_head),
    .count_o    (rsp_cnt)
  );

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = xfer_q.write;
  assign PADDR       = xfer_q.addr;
  assign PWDATA      = xfer_q.wdata;
  assign PSTRB       = xfer_q.strb;
  assign rsp_valid   = (rsp_cnt != 2'd0);
  assign rsp_rdata   = rsp_head.rdata;
  assign rsp_slverr  = rsp_head.slverr;
  assign rsp_timeout = rsp_head.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a behavioural APB slave, a command
// driver fed from a queue, and an expected-response queue checked in order.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { bit write; bit [31:0] addr; bit [31:0] wdata; bit [3:0] strb; } cmd_t;
  typedef struct { bit [31:0] rdata; bit slverr; bit timeout; } exp_t;

  cmd_t        pend_q[$];
  cmd_t        apb_q[$];
  exp_t        rsp_q[$];
  bit [31:0]   ref_mem [bit [31:0]];
  bit [31:0]   slv_mem [bit [31:0]];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, n_acc = 0, n_pop = 0, acc_cyc = 0, pop_cyc = 0;
  int          n_waits = 0, wait_cnt = 0;
  bit          hold_low = 1'b0;
  int          psel_cnt = 0, pen_cnt = 0, psel_first = -1, psel_last = -1;
  cmd_t        oc, sc;
  exp_t        oe, ge;

  function automatic bit [31:0] init_val(bit [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw, bit [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  function automatic bit [31:0] ref_rd(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic bit [31:0] slv_rd(bit [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // Command driver: presents the head of pend_q just after each rising edge.
  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    forever begin
      @(posedge PCLK); #1;
      if (pend_q.size() != 0) begin
        cmd_valid = 1'b1;
        cmd_write = pend_q[0].write;
        cmd_addr  = pend_q[0].addr;
        cmd_wdata = pend_q[0].wdata;
        cmd_strb  = pend_q[0].strb;
      end else begin
        cmd_valid = 1'b0;
      end
    end
  end

  // Accept observer (fills the scoreboard) and response checker.
  always @(negedge PCLK) begin
    #2;
    if (PRESETn && cmd_valid && cmd_ready) begin
      oc = pend_q.pop_front();
      n_acc++;
      acc_cyc = cyc;
      apb_q.push_back(oc);
      oe.slverr  = (oc.addr == 32'h4);
      oe.timeout = 1'b0;
      oe.rdata   = oc.write ? 32'h0 : ref_rd(oc.addr);
      if (hold_low) begin
        oe.rdata = 32'h0; oe.slverr = 1'b1; oe.timeout = 1'b1;
      end else if (oc.write && !oe.slverr) begin
        ref_mem[oc.addr] = merge(ref_rd(oc.addr), oc.wdata, oc.strb);
      end
      rsp_q.push_back(oe);
    end
    if (PRESETn && rsp_valid && rsp_ready) begin
      n_pop++;
      pop_cyc = cyc;
      check("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        ge = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, ge.rdata);
        check("rsp_slverr", rsp_slverr, ge.slverr);
        check("rsp_timeout", rsp_timeout, ge.timeout);
      end
    end
  end

  // Behavioural APB slave with programmable wait states; errors at 0x04.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; wait_cnt = 0;
    end else if (PSEL && PENABLE) begin
      if (hold_low || wait_cnt < n_waits) begin
        PREADY = 1'b0;
        wait_cnt++;
      end else begin
        PREADY   = 1'b1;
        wait_cnt = 0;
        PSLVERR  = (PADDR == 32'h4);
        check("apb_expected", apb_q.size() != 0, 1);
        if (apb_q.size() != 0) begin
          sc = apb_q.pop_front();
          check("paddr", PADDR, sc.addr);
          check("pwrite", PWRITE, sc.write);
          check("pstrb", PSTRB, sc.write ? sc.strb : 4'h0);
          if (sc.write) check("pwdata", PWDATA, sc.wdata);
        end
        if (PWRITE) begin
          PRDATA = 32'h5A5A_A5A5;
          if (!PSLVERR) slv_mem[PADDR] = merge(slv_rd(PADDR), PWDATA, PSTRB);
        end else begin
          PRDATA = slv_rd(PADDR);
        end
      end
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5A5A_A5A5; wait_cnt = 0;
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PSEL) begin
        psel_cnt++;
        if (psel_first < 0) psel_first = cyc;
        psel_last = cyc;
      end
      if (PENABLE) pen_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic drain(string tag, int max_cyc);
    int k = 0;
    while ((pend_q.size() != 0 || rsp_q.size() != 0) && k < max_cyc) begin
      @(posedge PCLK);
      k++;
    end
    check({tag, "_drained"}, (pend_q.size() == 0 && rsp_q.size() == 0), 1);
    #1;
  endtask

  task automatic clr_counts();
    psel_cnt = 0; pen_cnt = 0; psel_first = -1; psel_last = -1;
  endtask

  task automatic push_cmd(bit w, bit [31:0] a, bit [31:0] d, bit [3:0] s);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.strb = s;
    pend_q.push_back(c);
  endtask

  initial begin
    int a0, p0, k;
    PRESETn   = 1'b0;
    rsp_ready = 1'b1;
    tick(3);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_flags", {rsp_slverr, rsp_timeout}, 0);
    PRESETn = 1'b1;
    tick(2);

    // Write with three wait states.
    n_waits = 3;
    clr_counts();
    push_cmd(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
    drain("t1", 60);
    tick(2);
    check("t1_psel_cycles", psel_cnt, 5);
    check("t1_penable_cycles", pen_cnt, 4);

    // Zero-wait read-back and minimum latency.
    n_waits = 0;
    push_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    drain("t2", 40);
    check("t2_latency", pop_cyc - acc_cyc, 3);

    // Three reads back to back: PSEL must stay high throughout.
    clr_counts();
    p0 = n_pop;
    push_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    push_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    push_cmd(1'b0, 32'h28, 32'h0, 4'h0);
    drain("t3", 60);
    tick(2);
    check("t3_psel_cycles", psel_cnt, 6);
    check("t3_psel_contiguous", psel_last - psel_first + 1, 6);
    check("t3_responses", n_pop - p0, 3);

    // Slave error on 0x04, then a normal read.
    p0 = n_pop;
    push_cmd(1'b1, 32'h04, 32'h1234_5678, 4'h5);
    push_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    drain("t4", 60);
    check("t4_responses", n_pop - p0, 2);

    // Back-pressure: only two transfers may be in flight.
    rsp_ready = 1'b0;
    a0 = n_acc;
    p0 = n_pop;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h30 + 4 * i, 32'h0, 4'h0);
    tick(20);
    check("t5_accepted", n_acc - a0, 2);
    check("t5_popped", n_pop - p0, 0);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    tick(10);
    check("t5_accepted_after_pulse", n_acc - a0, 3);
    check("t5_popped_after_pulse", n_pop - p0, 1);
    rsp_ready = 1'b1;
    drain("t5", 80);
    check("t5_total_responses", n_pop - p0, 4);

    // Reset mid-ACCESS with a response already buffered.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    tick(8);
    n_waits = 6;
    push_cmd(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
    k = 0;
    while (!PENABLE && k < 30) begin
      @(negedge PCLK);
      k++;
    end
    #1;
    check("t6_in_access", PENABLE, 1);
    check("t6_buffered", rsp_valid, 1);
    PRESETn = 1'b0;
    #1;
    check("t6_rst_psel", PSEL, 0);
    check("t6_rst_penable", PENABLE, 0);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_rdata", rsp_rdata, 0);
    pend_q.delete();
    apb_q.delete();
    rsp_q.delete();
    tick(2);
    PRESETn   = 1'b1;
    rsp_ready = 1'b1;
    n_waits   = 0;
    tick(2);
    push_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    drain("t6_recover", 40);

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY held low: abort after 16 ACCESS cycles.
    hold_low = 1'b1;
    clr_counts();
    push_cmd(1'b0, 32'h28, 32'h0, 4'h0);
    drain("t7", 80);
    tick(2);
    check("t7_penable_cycles", pen_cnt, 16);
    check("t7_no_completion", apb_q.size(), 1);
    apb_q.delete();
    hold_low = 1'b0;
    push_cmd(1'b0, 32'h28, 32'h0, 4'h0);
    drain("t7_recover", 40);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that feeds the APB dual-port memory slave.
- Accepts simple commands on a valid/ready request channel and turns each one into a single APB transfer (SETUP, then ACCESS until PREADY).
- Returns read data and PSLVERR on a valid/ready response channel through a 2-entry response buffer, so back-to-back transfers run at full rate.
- Used by the integration testbench and by any future bus agent that drives the memory.

Parameters:
- ADDR_W, `APB_ADDR_WIDTH, address width.
- DATA_W, `APB_DATA_WIDTH, data width (multiple of 8).
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before abort (used only with APB_MASTER_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes (ignored for reads; driven as 0)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_slverr  out  1  PSLVERR captured at completion
- rsp_timeout  out  1  transfer aborted by timeout (tied 0 without the feature)
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

Behaviour:
- Clock and reset: one clock, PCLK. PRESETn is asynchronous, active-low.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, PSTRB = 0; response buffer empty (rsp_valid = 0, rsp_rdata = 0, rsp_slverr = 0, rsp_timeout = 0).
- FSM uses apb_fsm_enum {IDLE, SETUP, ACCESS}. All APB outputs are registered.
- IDLE: PSEL = 0, PENABLE = 0. On accept, go to SETUP and load PADDR, PWRITE, PWDATA and PSTRB from the command.
- SETUP: PSEL = 1, PENABLE = 0. Lasts exactly one cycle, then ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE, PWDATA and PSTRB are held stable until completion.
  - Stays in ACCESS while PREADY = 0.
  - On PREADY = 1, push {PRDATA if read else 0, PSLVERR, 0} into the response buffer.
  - If a command is accepted in the same cycle, go to SETUP with new fields loaded: PSEL stays high and PENABLE drops. Otherwise go to IDLE.
- Push/pop/count definitions:
  - push = ACCESS && PREADY.
  - pop = rsp_valid && rsp_ready.
  - rsp_cnt_next = rsp_cnt + push - pop.
- cmd_ready = (IDLE || (ACCESS && PREADY)) && rsp_cnt_next < 2. This guarantees a free slot exists for every in-flight transfer.
- Minimum latency: command accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with zero wait states.
- Response buffer: 2-entry FIFO, in-order. Output is registered from the head entry.
  - Simultaneous push and pop is allowed at any count.
  - Push never occurs when the buffer is full (guaranteed by cmd_ready).
- Boundaries:
  - PSLVERR is passed through unchanged. The error does not alter FSM flow.
  - Reset asserted mid-ACCESS: outputs go to reset values immediately and the buffered response is discarded.
  - cmd_valid while busy: held off by cmd_ready = 0. Command fields are sampled only on accept.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on SETUP and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES, the FSM forces IDLE (PSEL = 0, PENABLE = 0) and pushes {0, slverr = 1, timeout = 1}.
  - No back-to-back accept occurs on that cycle.
- Undefined: no counter. ACCESS waits indefinitely and rsp_timeout is tied 0.

Decomposition:
- apb_pkg gains apb_cmd_t {write, addr_t addr, data_t wdata, strb_t strb} and apb_rsp_t {data_t rdata, slverr, timeout}.
- apb_fsm_enum, addr_t, data_t and strb_t are reused from apb_pkg.
- Sub-module apb_rsp_fifo: 2-entry FIFO of apb_rsp_t with push/pop/count.

Test Plan:
- Write 0x20 = 0xDEADBEEF, strb 0xF, slave inserts 3 wait states -> PSEL high 5 cycles, PENABLE high 4; rsp_valid with slverr = 0, rdata = 0.
- Read 0x20 after the above, zero waits -> rsp_rdata = 0xDEADBEEF 3 cycles after accept.
- Three reads 0x20/0x24/0x28 offered back-to-back with rsp_ready = 1 -> PSEL never drops; three responses in order.
- Write to 0x04 -> PSLVERR = 1 at completion -> rsp_slverr = 1, next command proceeds normally.
- rsp_ready = 0, four commands offered -> exactly two complete; cmd_ready stays 0 until rsp_ready pulses; no response lost.
- Reset pulsed mid-ACCESS -> PSEL and PENABLE are 0 in the same cycle, rsp_valid = 0. With APB_MASTER_TIMEOUT_EN and PREADY held 0 -> abort after 16 ACCESS cycles, rsp_slverr = 1, rsp_timeout = 1.
